// File: rtl/bayer_win3x3.sv
// 3x3 Bayer neighbourhood extractor with reflect-101 borders.
// Two line buffers delay the raster stream by one and two lines, and a
// 3x3 register array holds the last three columns of the three rows. The
// raw taps sit around linear index n-W-1. A border mux then replaces the
// rows and columns that fall outside the frame with their mirrored
// counterparts.
module bayer_win3x3 #(
  parameter int PIXSIZE  = 16,
  parameter int ROW_W    = 13,
  parameter int COL_W    = 14,
  parameter int MAX_COLS = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ROW_W:0]     c_rows_r,
  input  logic [COL_W:0]     c_cols_r,
  input  logic [PIXSIZE-1:0] in_pix,
  input  logic               in_valid,
  input  logic               in_sof,
  output logic               in_ready,
  output logic [PIXSIZE-1:0] r0,
  output logic [PIXSIZE-1:0] r1,
  output logic [PIXSIZE-1:0] r2,
  output logic [PIXSIZE-1:0] r3,
  output logic [PIXSIZE-1:0] r4,
  output logic [PIXSIZE-1:0] r5,
  output logic [PIXSIZE-1:0] r6,
  output logic [PIXSIZE-1:0] r7,
  output logic [PIXSIZE-1:0] r8,
  output logic [ROW_W:0]     row,
  output logic [COL_W:0]     col,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [ROW_W:0] ROW_ONE = (ROW_W+1)'(1);
  localparam logic [COL_W:0] COL_ONE = (COL_W+1)'(1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
  state_t state;

  logic [PIXSIZE-1:0] lb1 [MAX_COLS];
  logic [PIXSIZE-1:0] lb2 [MAX_COLS];

  logic [ROW_W:0]     cr, crow;
  logic [COL_W:0]     cc, ccol, wcol, wsel, cc_eff;
  logic               have_sof, fill_second;
  logic [PIXSIZE-1:0] s0_1, s0_2, s1_1, s1_2, s2_1, s2_2;
  logic [PIXSIZE-1:0] t0, t1, t2;
  logic               accept, start, flush_go, shift_en, emit;
  logic [AW-1:0]      waddr;
  logic [PIXSIZE-1:0] raw [3][3];
  logic [PIXSIZE-1:0] win [9];

  // Picks the mirrored tap index when the neighbour falls outside the frame.
  function automatic logic [1:0] edge_sel(input logic [1:0] k, input logic lo_edge,
                                          input logic hi_edge);
    if (k == 2'd0 && lo_edge) return 2'd2;
    if (k == 2'd2 && hi_edge) return 2'd0;
    return k;
  endfunction

  // Input backpressure: FILL always takes data, RUN only when the output slot frees.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        FILL:    in_ready = 1'b1;
        RUN:     in_ready = !out_valid || out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept   = in_valid & in_ready;
  assign start    = accept & in_sof;
  assign flush_go = (state == FLUSH) & (~out_valid | out_ready);
  assign shift_en = (accept & (in_sof | have_sof)) | flush_go;
  assign emit     = ((state == RUN) & accept & ~in_sof) | flush_go;
  // A frame start always writes column 0, whatever the old column counter held.
  assign wsel     = start ? '0 : wcol;
  assign cc_eff   = start ? c_cols_r : cc;
  assign waddr    = AW'(wsel);
  assign t0       = (state == FLUSH) ? '0 : in_pix;
  assign t1       = lb1[waddr];
  assign t2       = lb2[waddr];

  // Raw taps: row 0 is two lines back, column 2 is the newest sample.
  always_comb begin
    raw[0][0] = s2_2; raw[0][1] = s2_1; raw[0][2] = t2;
    raw[1][0] = s1_2; raw[1][1] = s1_1; raw[1][2] = t1;
    raw[2][0] = s0_2; raw[2][1] = s0_1; raw[2][2] = t0;
  end

  // Reflect-101 border mux around the centre (crow, ccol).
  always_comb begin
    for (int unsigned j = 0; j < 3; j++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        win[j*3+i] = raw[edge_sel(2'(j), crow == '0, crow == cr)]
                        [edge_sel(2'(i), ccol == '0, ccol == cc)];
      end
    end
  end

  // Line buffers act as W-deep delay lines; their contents need no reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb1[waddr] <= t0;
      lb2[waddr] <= t1;
    end
  end

  // Control FSM, column shift registers and registered output window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      cr          <= '0;
      cc          <= '0;
      crow        <= '0;
      ccol        <= '0;
      wcol        <= '0;
      have_sof    <= 1'b0;
      fill_second <= 1'b0;
      s0_1 <= '0; s0_2 <= '0; s1_1 <= '0; s1_2 <= '0; s2_1 <= '0; s2_2 <= '0;
      r0 <= '0; r1 <= '0; r2 <= '0; r3 <= '0; r4 <= '0;
      r5 <= '0; r6 <= '0; r7 <= '0; r8 <= '0;
      row         <= '0;
      col         <= '0;
      out_valid   <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;

      if (shift_en) begin
        s0_2 <= s0_1; s0_1 <= t0;
        s1_2 <= s1_1; s1_1 <= t1;
        s2_2 <= s2_1; s2_1 <= t2;
        wcol <= (wsel == cc_eff) ? '0 : wsel + COL_ONE;
      end

      if (start) begin
        // New frame or abort: any window still pending in RUN is dropped
        // because acceptance in RUN implies the output slot was free.
        state       <= FILL;
        have_sof    <= 1'b1;
        cr          <= c_rows_r;
        cc          <= c_cols_r;
        fill_second <= 1'b0;
        crow        <= '0;
        ccol        <= '0;
      end else if (state == FILL && shift_en) begin
        if (wsel == cc) fill_second <= 1'b1;
        if (fill_second && wsel == '0) state <= RUN;
      end

      if (emit) begin
        r0 <= win[0]; r1 <= win[1]; r2 <= win[2];
        r3 <= win[3]; r4 <= win[4]; r5 <= win[5];
        r6 <= win[6]; r7 <= win[7]; r8 <= win[8];
        row       <= crow;
        col       <= ccol;
        out_valid <= 1'b1;
        if (ccol == cc) begin
          ccol <= '0;
          crow <= (crow == cr) ? '0 : crow + ROW_ONE;
        end else begin
          ccol <= ccol + COL_ONE;
        end
        if (state == RUN && crow == cr - ROW_ONE && ccol == cc - COL_ONE)
          state <= FLUSH;
        if (state == FLUSH && crow == cr && ccol == cc) begin
          state    <= FILL;
          have_sof <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_win3x3.sv
// Directed bench for bayer_win3x3: scenario table plus reset sequences.
module tb_bayer_win3x3;
  localparam int PW = 16;
  localparam int RW = 13;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW:0]   c_rows_r = '0;
  logic [CW:0]   c_cols_r = '0;
  logic [PW-1:0] in_pix = '0;
  logic          in_valid = 1'b0, in_sof = 1'b0, in_ready;
  logic [PW-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;
  logic [RW:0]   row;
  logic [CW:0]   col;
  logic          out_valid;
  logic          out_ready = 1'b1;

  bayer_win3x3 #(.PIXSIZE(PW), .ROW_W(RW), .COL_W(CW), .MAX_COLS(4096)) dut (
    .clk(clk), .rst(rst), .c_rows_r(c_rows_r), .c_cols_r(c_cols_r),
    .in_pix(in_pix), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7), .r8(r8),
    .row(row), .col(col), .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  typedef logic [0:8][PW-1:0] win_t;
  win_t cur;
  assign cur = {r0, r1, r2, r3, r4, r5, r6, r7, r8};

  typedef struct {
    int   rows_r;
    int   cols_r;
    bit   toggle;     // out_ready alternates 1/0
    int   abort_at;   // input index where a fresh sof is injected, -1 none
    int   exp_count;
    int   exp_flush;  // windows produced while in_ready=0
    win_t first;
    win_t last;
  } vec_t;

  vec_t tab [5];
  int checks = 0;
  int errors = 0;

  // Independent 2D reference: pixel value is its raster index.
  function automatic win_t model_win(input int r, input int c, input int rr, input int cc);
    win_t w;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int y, x;
        y = r + dr; x = c + dc;
        if (y < 0) y = 1; else if (y > rr) y = rr - 1;
        if (x < 0) x = 1; else if (x > cc) x = cc - 1;
        w[(dr+1)*3 + (dc+1)] = PW'(y*(cc+1) + x);
      end
    end
    return w;
  endfunction

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_win(input string nm, input int er, input int ec, input win_t e);
    checks++;
    if (cur !== e || int'(row) != er || int'(col) != ec) begin
      errors++;
      $display("FAIL %s: got row %0d col %0d win %h expected row %0d col %0d win %h",
               nm, row, col, cur, er, ec, e);
    end
  endtask

  // Streams one scenario and checks every transferred window.
  task automatic run_frame(input int v);
    vec_t t;
    int rr, cc, total, idx, outs, flush_outs, acc, lat, viol, cyc, extra, done_cyc;
    bit aborted, do_abort, ld_ir;
    t = tab[v];
    rr = t.rows_r; cc = t.cols_r; total = (rr+1)*(cc+1);
    idx = 0; outs = 0; flush_outs = 0; acc = 0; lat = -1; viol = 0; cyc = 0;
    extra = 0; done_cyc = -1; aborted = 0; ld_ir = 1;
    c_rows_r = RW'(rr); c_cols_r = CW'(cc);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_ready = t.toggle ? ((cyc % 2) == 1) : 1'b1;
      do_abort = !aborted && t.abort_at >= 0 && idx == t.abort_at;
      if (idx < total) begin
        in_valid = 1'b1;
        in_pix   = do_abort ? '0 : PW'(idx);
        in_sof   = (idx == 0) || do_abort;
      end else begin
        in_valid = 1'b0;
        in_sof   = 1'b0;
      end
      #1;
      if (idx < total && out_valid && !out_ready && in_ready) viol++;
      if (out_valid && lat < 0) lat = acc;
      if (out_valid && out_ready) begin
        if (outs >= total) extra++;
        else begin
          check_win($sformatf("win%0d_s%0d", outs, v), outs/(cc+1), outs%(cc+1),
                    model_win(outs/(cc+1), outs%(cc+1), rr, cc));
          if (outs == 0) check_win($sformatf("first_s%0d", v), 0, 0, t.first);
          if (outs == total-1) check_win($sformatf("last_s%0d", v), rr, cc, t.last);
          if (!ld_ir) flush_outs++;
        end
        outs++;
      end
      // Window loaded at this edge (slot free) records whether input was blocked.
      if (!out_valid || out_ready) ld_ir = in_ready;
      if (in_valid && in_ready) begin
        acc++;
        if (do_abort) begin
          aborted = 1;
          outs = 0;
          flush_outs = 0;
          idx = 1;
        end else idx++;
      end
      if (outs >= total && done_cyc < 0) done_cyc = cyc;
      if (done_cyc >= 0 && cyc - done_cyc >= 12) break;
    end
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    check_int($sformatf("count_s%0d", v), outs, t.exp_count);
    check_int($sformatf("extra_s%0d", v), extra, 0);
    check_int($sformatf("flush_s%0d", v), flush_outs, t.exp_flush);
    // First window is paired with input index W+1, so W+2 inputs are in.
    check_int($sformatf("latency_s%0d", v), lat, cc + 3);
    check_int($sformatf("stall_ready_s%0d", v), viol, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tab[0] = '{3, 3, 1'b0, -1, 16, 5,
               {16'd5, 16'd4, 16'd5, 16'd1, 16'd0, 16'd1, 16'd5, 16'd4, 16'd5},
               {16'd10, 16'd11, 16'd10, 16'd14, 16'd15, 16'd14, 16'd10, 16'd11, 16'd10}};
    tab[1] = tab[0];
    tab[1].toggle = 1'b1;
    tab[2] = tab[0];
    tab[2].abort_at = 9;
    tab[3] = '{1, 1, 1'b0, -1, 4, 3,
               {16'd3, 16'd2, 16'd3, 16'd1, 16'd0, 16'd1, 16'd3, 16'd2, 16'd3},
               {16'd0, 16'd1, 16'd0, 16'd2, 16'd3, 16'd2, 16'd0, 16'd1, 16'd0}};
    tab[4] = '{2, 4, 1'b0, -1, 15, 6,
               {16'd6, 16'd5, 16'd6, 16'd1, 16'd0, 16'd1, 16'd6, 16'd5, 16'd6},
               {16'd8, 16'd9, 16'd8, 16'd13, 16'd14, 16'd13, 16'd8, 16'd9, 16'd8}};

    // Power-on reset state.
    #2 rst = 1'b1;
    #1;
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_row_col", int'(row) + int'(col), 0);
    check_int("rst_window_zero", int'(cur != '0), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) run_frame(v);

    // Reset asserted mid-RUN: 8 pixels of a 4x4 frame, then async reset.
    c_rows_r = RW'(3); c_cols_r = CW'(3); out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 8; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = (n == 0); in_pix = PW'(n);
      #1;
      if (in_ready) n++;
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    #1;
    check_int("pre_rst_valid", int'(out_valid), 1);
    #1 rst = 1'b1;
    #1;
    check_int("midrst_out_valid", int'(out_valid), 0);
    check_int("midrst_in_ready", int'(in_ready), 0);
    check_int("midrst_row_col", int'(row) + int'(col), 0);
    check_int("midrst_r4", int'(r4), 0);
    @(negedge clk);
    rst = 1'b0;
    // Non-sof pixels before the frame must be ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b0; in_pix = 16'hBEEF;
    end
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
